// File: rtl/register_file_pkg.sv
// register_file_pkg
// Shared definitions for the multiport register file: the clear-sweep state
// encoding and the register-count derivation from the address width.
package register_file_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } clear_state_e;

  function automatic int num_regs(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/register_file_clear_fsm.sv
// register_file_clear_fsm
// Sequencer that zeroes the register array one entry per cycle on request.
//   clk_i            clock, rising edge
//   rst_ni           synchronous active-low reset
//   clear_request_i  start a sweep (only honoured in IDLE)
//   write_enable_i   write strobe from writeback, used to flag refused writes
//   clear_busy_o     sweep in progress
//   clear_done_o     one-cycle pulse after the last entry is cleared
//   write_dropped_o  write refused because a sweep is active
//   clear_en_o       per-entry clear strobe for the array
//   clear_idx_o      entry cleared at the next edge while clear_en_o is high
//
// state | meaning
// IDLE  | waiting for clear_request_i
// SWEEP | clearing entry idx_q each cycle, writes refused
// DONE  | sweep finished, clear_done_o pulses, writes accepted
module register_file_clear_fsm
  import register_file_pkg::*;
#(
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_request_i,
  input  logic                  write_enable_i,
  output logic                  clear_busy_o,
  output logic                  clear_done_o,
  output logic                  write_dropped_o,
  output logic                  clear_en_o,
  output logic [ADDR_WIDTH-1:0] clear_idx_o
);

  localparam logic [ADDR_WIDTH-1:0] LastIdx = {ADDR_WIDTH{1'b1}};

  clear_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (clear_request_i) begin
          state_d = SWEEP;
          idx_d   = '0;
        end
      end
      SWEEP: begin
        idx_d = idx_q + ADDR_WIDTH'(1);
        if (idx_q == LastIdx) begin
          state_d = DONE;
          idx_d   = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign clear_busy_o    = (state_q == SWEEP);
  assign clear_done_o    = (state_q == DONE);
  assign write_dropped_o = write_enable_i && clear_busy_o;
  assign clear_en_o      = clear_busy_o;
  assign clear_idx_o     = idx_q;

endmodule

// File: rtl/register_file_multiport.sv
// register_file_multiport
// Parametrised register file with N combinational read ports, one write port,
// optional hardwired-zero register 0, optional write-to-read bypass and a
// run-time clear sweep.
//   clock, reset_n       clock and synchronous active-low reset
//   read_register_ports  packed read addresses, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//   read_data_ports      packed read data, port p at [p*DATA_WIDTH +: DATA_WIDTH]
//   write_register/data/enable  writeback port
//   clear_request        start a clear sweep
//   clear_busy, clear_done, write_dropped  sweep status
module register_file_multiport
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 2,
  parameter int NUM_READ_PORTS = 2,
  parameter int ZERO_REG       = 1,
  parameter int BYPASS         = 1
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0] read_register_ports,
  output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] read_data_ports,
  input  logic [ADDR_WIDTH-1:0]                write_register,
  input  logic [DATA_WIDTH-1:0]                write_data,
  input  logic                                 write_enable,
  input  logic                                 clear_request,
  output logic                                 clear_busy,
  output logic                                 clear_done,
  output logic                                 write_dropped
);

  localparam int NumRegs = num_regs(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] regs_q [NumRegs];
  logic                  clear_en;
  logic [ADDR_WIDTH-1:0] clear_idx;
  logic                  wr_accept;

  register_file_clear_fsm #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_clear_fsm (
    .clk_i          (clock),
    .rst_ni         (reset_n),
    .clear_request_i(clear_request),
    .write_enable_i (write_enable),
    .clear_busy_o   (clear_busy),
    .clear_done_o   (clear_done),
    .write_dropped_o(write_dropped),
    .clear_en_o     (clear_en),
    .clear_idx_o    (clear_idx)
  );

  // Protected register 0 never accepts a write, so it is never bypassed either.
  assign wr_accept = write_enable && !clear_busy &&
                     !((ZERO_REG != 0) && (write_register == '0));

  // Sweep and accepted write are mutually exclusive (writes refused while busy).
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < NumRegs; i++) regs_q[i] <= '0;
    end else if (clear_en) begin
      regs_q[clear_idx] <= '0;
    end else if (wr_accept) begin
      regs_q[write_register] <= write_data;
    end
  end

  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;

    assign addr = read_register_ports[p*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      data = regs_q[addr];
      if ((BYPASS != 0) && wr_accept && (write_register == addr)) data = write_data;
      if ((ZERO_REG != 0) && (addr == '0)) data = '0;
    end

    assign read_data_ports[p*DATA_WIDTH +: DATA_WIDTH] = data;
  end

endmodule

// File: tb/tb_register_file_multiport.sv
module tb_register_file_multiport;
  localparam int DW  = 32, AW  = 2, NP  = 2, NR  = 4;
  localparam int DWC = 16, AWC = 4, NPC = 3;
  localparam int RAW = NP * AW;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic           reset_n;
  logic [RAW-1:0] rd_addr;
  logic [AW-1:0]  wr_addr;
  logic [DW-1:0]  wr_data;
  logic           we, req;
  logic [NP*DW-1:0] rd_a, rd_b;
  logic busy_a, done_a, drop_a, busy_b, done_b, drop_b;

  logic [NPC*AWC-1:0] rd_addr_c;
  logic [AWC-1:0]     wr_addr_c;
  logic [DWC-1:0]     wr_data_c;
  logic               we_c, req_c;
  logic [NPC*DWC-1:0] rd_c;
  logic busy_c, done_c, drop_c;

  register_file_multiport dut_a (
    .clock(clock), .reset_n(reset_n), .read_register_ports(rd_addr), .read_data_ports(rd_a),
    .write_register(wr_addr), .write_data(wr_data), .write_enable(we), .clear_request(req),
    .clear_busy(busy_a), .clear_done(done_a), .write_dropped(drop_a));

  register_file_multiport #(.BYPASS(0)) dut_b (
    .clock(clock), .reset_n(reset_n), .read_register_ports(rd_addr), .read_data_ports(rd_b),
    .write_register(wr_addr), .write_data(wr_data), .write_enable(we), .clear_request(req),
    .clear_busy(busy_b), .clear_done(done_b), .write_dropped(drop_b));

  register_file_multiport #(.DATA_WIDTH(DWC), .ADDR_WIDTH(AWC), .NUM_READ_PORTS(NPC)) dut_c (
    .clock(clock), .reset_n(reset_n), .read_register_ports(rd_addr_c), .read_data_ports(rd_c),
    .write_register(wr_addr_c), .write_data(wr_data_c), .write_enable(we_c), .clear_request(req_c),
    .clear_busy(busy_c), .clear_done(done_c), .write_dropped(drop_c));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: array contents plus "entries left to clear" and a done flag.
  logic [DW-1:0] m_mem [NR];
  int            m_left;
  bit            m_done;

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a, input bit byp);
    if (a == 0) return '0;
    if (byp && we && m_left == 0 && wr_addr == a) return wr_data;
    return m_mem[a];
  endfunction

  task automatic model_step();
    bit was_done;
    if (!reset_n) begin
      for (int i = 0; i < NR; i++) m_mem[i] = '0;
      m_left = 0;
      m_done = 0;
    end else if (m_left > 0) begin
      m_mem[NR - m_left] = '0;
      m_left--;
      m_done = (m_left == 0);
    end else begin
      was_done = m_done;
      m_done = 0;
      if (we && wr_addr != 0) m_mem[wr_addr] = wr_data;
      if (!was_done && req) m_left = NR;
    end
  endtask

  task automatic check_ab(input string tag);
    for (int p = 0; p < NP; p++) begin
      chk({tag, "/rdA"}, 64'(rd_a[p*DW +: DW]), 64'(m_read(rd_addr[p*AW +: AW], 1'b1)));
      chk({tag, "/rdB"}, 64'(rd_b[p*DW +: DW]), 64'(m_read(rd_addr[p*AW +: AW], 1'b0)));
    end
    chk({tag, "/busyA"}, 64'(busy_a), 64'(m_left > 0));
    chk({tag, "/doneA"}, 64'(done_a), 64'(m_done));
    chk({tag, "/dropA"}, 64'(drop_a), 64'(we && m_left > 0));
    chk({tag, "/busyB"}, 64'(busy_b), 64'(m_left > 0));
    chk({tag, "/doneB"}, 64'(done_b), 64'(m_done));
    chk({tag, "/dropB"}, 64'(drop_b), 64'(we && m_left > 0));
  endtask

  task automatic finish_cycle();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic cycle_ab(input string tag);
    @(negedge clock);
    check_ab(tag);
    finish_cycle();
  endtask

  typedef struct {
    bit            we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] ra0, ra1;
    logic [DW-1:0] e0, e1, e0n, e1n;
  } vec_t;

  vec_t tbl [8];

  initial begin
    tbl[0] = '{1'b1, 2'd2, 32'hDEADBEEF, 2'd0, 2'd3, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[1] = '{1'b0, 2'd0, 32'h0, 2'd2, 2'd3, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0};
    tbl[2] = '{1'b1, 2'd0, 32'h12345678, 2'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[3] = '{1'b0, 2'd0, 32'h0, 2'd0, 2'd2, 32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF};
    tbl[4] = '{1'b1, 2'd1, 32'hA5A5A5A5, 2'd2, 2'd1, 32'hDEADBEEF, 32'hA5A5A5A5, 32'hDEADBEEF, 32'h0};
    tbl[5] = '{1'b0, 2'd0, 32'h0, 2'd1, 2'd2, 32'hA5A5A5A5, 32'hDEADBEEF, 32'hA5A5A5A5, 32'hDEADBEEF};
    tbl[6] = '{1'b1, 2'd1, 32'h0, 2'd1, 2'd3, 32'h0, 32'h0, 32'hA5A5A5A5, 32'h0};
    tbl[7] = '{1'b0, 2'd0, 32'h0, 2'd1, 2'd2, 32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF};

    reset_n = 1'b0; rd_addr = '0; wr_addr = '0; wr_data = '0; we = 1'b0; req = 1'b0;
    rd_addr_c = '0; wr_addr_c = '0; wr_data_c = '0; we_c = 1'b0; req_c = 1'b0;
    for (int i = 0; i < NR; i++) m_mem[i] = 32'hFFFF_FFFF;
    m_left = 0; m_done = 0;

    // Reset, with writes pending to make sure they are not taken.
    we = 1'b1; wr_addr = 2'd1; wr_data = 32'h5555_5555;
    finish_cycle();
    finish_cycle();
    reset_n = 1'b1; we = 1'b0; rd_addr = {2'd1, 2'd2};
    @(negedge clock);
    chk("rst/busyA", 64'(busy_a), 64'(0));
    chk("rst/doneA", 64'(done_a), 64'(0));
    chk("rst/rdA", 64'(rd_a), 64'(0));
    chk("rst/rdB", 64'(rd_b), 64'(0));
    chk("rst/busyC", 64'(busy_c), 64'(0));
    chk("rst/rdC", 64'(rd_c), 64'(0));
    check_ab("rst");
    finish_cycle();

    // Parametrised build: 16-bit, 16 entries, 3 ports.
    begin
      int  nb;
      bit  seen;
      we_c = 1'b1; wr_addr_c = 4'd15; wr_data_c = 16'hBEEF;
      rd_addr_c = {4'd0, 4'd14, 4'd15};
      finish_cycle();
      we_c = 1'b0;
      @(negedge clock);
      chk("C/p0", 64'(rd_c[15:0]), 64'(16'hBEEF));
      chk("C/p1", 64'(rd_c[31:16]), 64'(0));
      chk("C/p2", 64'(rd_c[47:32]), 64'(0));
      finish_cycle();
      req_c = 1'b1;
      finish_cycle();
      req_c = 1'b0;
      nb = 0; seen = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clock);
        if (done_c) begin
          seen = 1;
          break;
        end
        if (busy_c) nb++;
        finish_cycle();
      end
      chk("C/done_seen", 64'(seen), 64'(1));
      chk("C/sweep_len", 64'(nb), 64'(16));
      finish_cycle();
      @(negedge clock);
      chk("C/cleared", 64'(rd_c[15:0]), 64'(0));
      chk("C/done_pulse", 64'(done_c), 64'(0));
      finish_cycle();
    end

    // Table-driven write/read, zero register and bypass.
    for (int i = 0; i < 8; i++) begin
      we = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
      rd_addr = {tbl[i].ra1, tbl[i].ra0};
      @(negedge clock);
      chk($sformatf("tbl%0d/A0", i), 64'(rd_a[31:0]), 64'(tbl[i].e0));
      chk($sformatf("tbl%0d/A1", i), 64'(rd_a[63:32]), 64'(tbl[i].e1));
      chk($sformatf("tbl%0d/B0", i), 64'(rd_b[31:0]), 64'(tbl[i].e0n));
      chk($sformatf("tbl%0d/B1", i), 64'(rd_b[63:32]), 64'(tbl[i].e1n));
      chk($sformatf("tbl%0d/drop", i), 64'(drop_a), 64'(0));
      check_ab($sformatf("tbl%0d", i));
      finish_cycle();
    end

    // Clear sweep with a refused write in the middle.
    we = 1'b1; wr_addr = 2'd1; wr_data = 32'h11; cycle_ab("fill1");
    wr_addr = 2'd2; wr_data = 32'h22; cycle_ab("fill2");
    wr_addr = 2'd3; wr_data = 32'h33; cycle_ab("fill3");
    we = 1'b0; req = 1'b1;
    @(negedge clock);
    chk("sw/T_busy", 64'(busy_a), 64'(0));
    check_ab("swT");
    finish_cycle();
    req = 1'b0;
    rd_addr = {2'd3, 2'd1};
    for (int k = 1; k <= 6; k++) begin
      we = (k == 2); wr_addr = 2'd3; wr_data = 32'h99;
      @(negedge clock);
      chk($sformatf("sw/T%0d_busy", k), 64'(busy_a), 64'(k <= 4));
      chk($sformatf("sw/T%0d_done", k), 64'(done_a), 64'(k == 5));
      chk($sformatf("sw/T%0d_drop", k), 64'(drop_a), 64'(k == 2));
      check_ab($sformatf("sw%0d", k));
      finish_cycle();
    end
    we = 1'b0;
    for (int a = 1; a < NR; a++) begin
      rd_addr = {2'd0, AW'(a)};
      @(negedge clock);
      chk($sformatf("sw/r%0d_zero", a), 64'(rd_a[31:0]), 64'(0));
      check_ab("swpost");
      finish_cycle();
    end

    // Reset in the middle of a sweep.
    we = 1'b1; wr_addr = 2'd2; wr_data = 32'h77; cycle_ab("mr_fill");
    we = 1'b0; req = 1'b1; cycle_ab("mrT");
    req = 1'b0; cycle_ab("mrT1");
    reset_n = 1'b0; cycle_ab("mrT2");
    reset_n = 1'b1;
    rd_addr = {2'd3, 2'd2};
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      chk("mr/busy", 64'(busy_a), 64'(0));
      chk("mr/done", 64'(done_a), 64'(0));
      chk("mr/rd", 64'(rd_a), 64'(0));
      check_ab("mr");
      finish_cycle();
    end
    req = 1'b1; cycle_ab("mr_req");
    req = 1'b0;
    @(negedge clock);
    chk("mr/restart_busy", 64'(busy_a), 64'(1));
    check_ab("mr_restart");
    finish_cycle();
    for (int k = 0; k < 6; k++) cycle_ab("mr_tail");

    // Randomised traffic against the model.
    for (int k = 0; k < 400; k++) begin
      we      = 1'($urandom_range(0, 1));
      wr_addr = AW'($urandom);
      wr_data = $urandom;
      rd_addr = RAW'($urandom);
      req     = ($urandom_range(0, 7) == 0);
      reset_n = ($urandom_range(0, 79) != 0);
      cycle_ab("rnd");
    end
    reset_n = 1'b1; we = 1'b0; req = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
